// File: rtl/ii_sii_stream_gen.sv
// ii_sii_stream_gen
//   Streaming integral image (II) and squared integral image (SII) generator.
//   One pixel stream in, one aligned II/SII word stream out, one register
//   stage of latency, sustained throughput of one pixel per cycle.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   din_valid/din_ready   : input handshake
//   din_data              : unsigned pixel
//   din_eot               : bit0 = last pixel of row, bit1 = last pixel of frame
//   dout_valid/dout_ready : output handshake
//   dout_ii, dout_sii     : II(x,y) and SII(x,y), modulo 2^W_II / 2^W_SII
//   dout_eot              : din_eot of the pixel that produced the word
//   err_row_len           : sticky row-length error, cleared only by rst
//
// Handshake: a word moves across an interface on a rising clk edge where
//   valid && ready are both high. A producer holding valid keeps its data
//   stable until the transfer happens. Here din_ready = !dout_valid ||
//   dout_ready, so the input stalls exactly when the output word is stalled,
//   and a drain plus a new accept in the same cycle reload the output stage.
module ii_sii_stream_gen #(
  parameter int W_DATA    = 8,
  parameter int IMG_WIDTH = 24,
  parameter int W_II      = 18,
  parameter int W_SII     = 26,
  parameter int SII_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [W_DATA-1:0] din_data,
  input  logic [1:0]        din_eot,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_II-1:0]   dout_ii,
  output logic [W_SII-1:0]  dout_sii,
  output logic [1:0]        dout_eot,
  output logic              err_row_len
);

  localparam int X_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);

  // ROW0: the column buffers hold nothing valid for this frame yet.
  typedef enum logic {ROW0 = 1'b0, ROWN = 1'b1} state_t;

  state_t             state;
  state_t             state_next;
  logic               first_row;
  logic               accept;
  logic [X_W-1:0]     x;
  logic               last_col;
  logic [W_II-1:0]    rs_ii;
  logic [W_II-1:0]    rs_ii_next;
  logic [W_II-1:0]    ii_next;
  logic [W_II-1:0]    cb_ii [IMG_WIDTH];
  logic [W_SII-1:0]   sii_next;

  assign din_ready = !dout_valid || dout_ready;
  assign accept    = din_valid && din_ready;
  assign last_col  = (x == X_LAST);

  // ---------------- row FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ROW0;
    else     state <= state_next;
  end

  // ---------------- row FSM: next state ----------------
  // A frame end always returns to ROW0, even on a short row, so the next
  // frame never mixes with stale column-buffer contents.
  always_comb begin
    state_next = state;
    if (accept) begin
      if (din_eot[0])    state_next = din_eot[1] ? ROW0 : ROWN;
      else if (last_col) state_next = ROWN;
    end
  end

  // ---------------- row FSM: outputs ----------------
  always_comb begin
    first_row = (state == ROW0);
  end

  // Column counter: wraps on row end or when the row overruns the width.
  always_ff @(posedge clk) begin
    if (rst)         x <= '0;
    else if (accept) x <= (din_eot[0] || last_col) ? '0 : x + X_W'(1);
  end

  // Row length is wrong whenever the eot marker and the last column disagree.
  always_ff @(posedge clk) begin
    if (rst)                                    err_row_len <= 1'b0;
    else if (accept && (din_eot[0] != last_col)) err_row_len <= 1'b1;
  end

  // ---------------- II datapath ----------------
  always_comb begin
    rs_ii_next = ((x == '0) ? '0 : rs_ii) + W_II'(din_data);
    ii_next    = rs_ii_next + (first_row ? '0 : cb_ii[x]);
  end

  always_ff @(posedge clk) begin
    if (rst)         rs_ii <= '0;
    else if (accept) rs_ii <= rs_ii_next;
  end

  // Never cleared: first_row masks whatever a previous frame left behind.
  // The read of cb_ii[x] above sees the value before this write.
  always_ff @(posedge clk) begin
    if (accept) cb_ii[x] <= ii_next;
  end

  // ---------------- SII datapath ----------------
  generate
    if (SII_EN != 0) begin : g_sii
      logic [2*W_DATA-1:0] p_ext;
      logic [2*W_DATA-1:0] sq;
      logic [W_SII-1:0]    rs_sii;
      logic [W_SII-1:0]    rs_sii_next;
      logic [W_SII-1:0]    cb_sii [IMG_WIDTH];

      assign p_ext = {{W_DATA{1'b0}}, din_data};
      assign sq    = p_ext * p_ext;

      always_comb begin
        rs_sii_next = ((x == '0) ? '0 : rs_sii) + W_SII'(sq);
        sii_next    = rs_sii_next + (first_row ? '0 : cb_sii[x]);
      end

      always_ff @(posedge clk) begin
        if (rst)         rs_sii <= '0;
        else if (accept) rs_sii <= rs_sii_next;
      end

      always_ff @(posedge clk) begin
        if (accept) cb_sii[x] <= sii_next;
      end
    end else begin : g_no_sii
      assign sii_next = '0;
    end
  endgenerate

  // ---------------- output stage ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_ii    <= '0;
      dout_sii   <= '0;
      dout_eot   <= '0;
    end else if (accept) begin
      dout_valid <= 1'b1;
      dout_ii    <= ii_next;
      dout_sii   <= sii_next;
      dout_eot   <= din_eot;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ii_sii_stream_gen.sv
// Testbench for ii_sii_stream_gen.
//   dut_a : IMG_WIDTH=4, SII enabled
//   dut_c : IMG_WIDTH=4, SII disabled, driven with the same stream as dut_a
//   dut_b : default geometry (24x24)
module tb_ii_sii_stream_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT signals ----------------
  logic        din_valid_a, dout_ready_a;
  logic [7:0]  din_data_a;
  logic [1:0]  din_eot_a;
  logic        din_ready_a, dout_valid_a, err_a;
  logic [17:0] dout_ii_a;
  logic [25:0] dout_sii_a;
  logic [1:0]  dout_eot_a;

  logic        din_ready_c, dout_valid_c, err_c;
  logic [17:0] dout_ii_c;
  logic [25:0] dout_sii_c;
  logic [1:0]  dout_eot_c;

  logic        din_valid_b, dout_ready_b;
  logic [7:0]  din_data_b;
  logic [1:0]  din_eot_b;
  logic        din_ready_b, dout_valid_b, err_b;
  logic [17:0] dout_ii_b;
  logic [25:0] dout_sii_b;
  logic [1:0]  dout_eot_b;

  ii_sii_stream_gen #(.IMG_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .din_valid(din_valid_a), .din_ready(din_ready_a),
    .din_data(din_data_a), .din_eot(din_eot_a),
    .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .dout_ii(dout_ii_a), .dout_sii(dout_sii_a), .dout_eot(dout_eot_a),
    .err_row_len(err_a)
  );

  ii_sii_stream_gen #(.IMG_WIDTH(4), .SII_EN(0)) dut_c (
    .clk(clk), .rst(rst),
    .din_valid(din_valid_a), .din_ready(din_ready_c),
    .din_data(din_data_a), .din_eot(din_eot_a),
    .dout_valid(dout_valid_c), .dout_ready(dout_ready_a),
    .dout_ii(dout_ii_c), .dout_sii(dout_sii_c), .dout_eot(dout_eot_c),
    .err_row_len(err_c)
  );

  ii_sii_stream_gen dut_b (
    .clk(clk), .rst(rst),
    .din_valid(din_valid_b), .din_ready(din_ready_b),
    .din_data(din_data_b), .din_eot(din_eot_b),
    .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .dout_ii(dout_ii_b), .dout_sii(dout_sii_b), .dout_eot(dout_eot_b),
    .err_row_len(err_b)
  );

  // ---------------- scoreboard queues ----------------
  logic [17:0] exp_ii_q[$];
  logic [25:0] exp_sii_q[$];
  logic [1:0]  exp_eot_q[$];
  logic [7:0]  pix_q[$];
  logic [1:0]  pix_eot_q[$];

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_a(input logic [7:0] p, input logic [1:0] e);
    bit got = 1'b0;
    din_valid_a = 1'b1; din_data_a = p; din_eot_a = e;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (din_ready_a) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout_a: din_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    din_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p, input logic [1:0] e);
    bit got = 1'b0;
    din_valid_b = 1'b1; din_data_b = p; din_eot_b = e;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (din_ready_b) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout_b: din_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    din_valid_b = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    din_valid_a = 1'b0; din_data_a = '0; din_eot_a = '0; dout_ready_a = 1'b1;
    din_valid_b = 1'b0; din_data_b = '0; din_eot_b = '0; dout_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (dout_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", dout_valid_a); end
    checks++; if (dout_ii_a !== 18'd0) begin errors++; $display("FAIL reset_ii: got %0d exp 0", dout_ii_a); end
    checks++; if (dout_sii_a !== 26'd0) begin errors++; $display("FAIL reset_sii: got %0d exp 0", dout_sii_a); end
    checks++; if (dout_eot_a !== 2'b00) begin errors++; $display("FAIL reset_eot: got %b exp 00", dout_eot_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", err_a); end
    checks++; if (din_ready_a !== 1'b1 || din_ready_c !== 1'b1) begin
      errors++; $display("FAIL reset_din_ready: got %0b/%0b exp 1/1", din_ready_a, din_ready_c);
    end
    checks++; if (dout_valid_b !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL reset_b: got valid=%0b err=%0b exp 0/0", dout_valid_b, err_b);
    end
  endtask

  task automatic test_all_ones();
    int c0 = cyc;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        logic [1:0] e;
        int ex;
        e  = {(y == 3 && x == 3), (x == 3)};
        ex = (x + 1) * (y + 1);
        send_a(8'd1, e);
        checks++; if (dout_valid_a !== 1'b1) begin errors++; $display("FAIL ones_valid(%0d,%0d): got %0b exp 1", x, y, dout_valid_a); end
        checks++; if (dout_ii_a !== 18'(ex)) begin errors++; $display("FAIL ones_ii(%0d,%0d): got %0d exp %0d", x, y, dout_ii_a, ex); end
        checks++; if (dout_sii_a !== 26'(ex)) begin errors++; $display("FAIL ones_sii(%0d,%0d): got %0d exp %0d", x, y, dout_sii_a, ex); end
        checks++; if (dout_eot_a !== e) begin errors++; $display("FAIL ones_eot(%0d,%0d): got %b exp %b", x, y, dout_eot_a, e); end
      end
    end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL ones_err: got %0b exp 0", err_a); end
    checks++; if (cyc - c0 != 16) begin errors++; $display("FAIL ones_throughput: got %0d cycles exp 16", cyc - c0); end
  endtask

  task automatic test_full_scale();
    int c0 = cyc;
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 24; x++) begin
        send_b(8'd255, {(y == 23 && x == 23), (x == 23)});
        if (y == 0 && x == 23) begin
          checks++; if (dout_ii_b !== 18'd6120 || dout_sii_b !== 26'd1560600 || dout_eot_b !== 2'b01) begin
            errors++; $display("FAIL full_row0_end: got ii=%0d sii=%0d eot=%b exp 6120/1560600/01", dout_ii_b, dout_sii_b, dout_eot_b);
          end
        end
      end
    end
    checks++; if (cyc - c0 != 576) begin errors++; $display("FAIL full_throughput: got %0d cycles exp 576", cyc - c0); end
    checks++; if (dout_ii_b !== 18'd146880) begin errors++; $display("FAIL full_final_ii: got %0d exp 146880", dout_ii_b); end
    checks++; if (dout_sii_b !== 26'd37454400) begin errors++; $display("FAIL full_final_sii: got %0d exp 37454400", dout_sii_b); end
    checks++; if (dout_eot_b !== 2'b11) begin errors++; $display("FAIL full_final_eot: got %b exp 11", dout_eot_b); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL full_err: got %0b exp 0", err_b); end
  endtask

  task automatic test_back_to_back();
    // Second frame on dut_b follows the first with no gap.
    send_b(8'd255, 2'b00);
    checks++; if (dout_ii_b !== 18'd255 || dout_sii_b !== 26'd65025) begin
      errors++; $display("FAIL b2b_first: got ii=%0d sii=%0d exp 255/65025", dout_ii_b, dout_sii_b);
    end
    send_b(8'd255, 2'b00);
    checks++; if (dout_ii_b !== 18'd510 || dout_sii_b !== 26'd130050) begin
      errors++; $display("FAIL b2b_second: got ii=%0d sii=%0d exp 510/130050", dout_ii_b, dout_sii_b);
    end
  endtask

  task automatic test_backpressure();
    int img [4][4];
    int n = 32;
    int got = 0;
    bit stalled = 1'b0;
    logic [17:0] h_ii;
    logic [25:0] h_sii;
    logic [1:0]  h_eot;
    exp_ii_q.delete(); exp_sii_q.delete(); exp_eot_q.delete();
    pix_q.delete(); pix_eot_q.delete();
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++)
          img[y][x] = $urandom_range(0, 255);
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 4; x++) begin
          int s = 0;
          int s2 = 0;
          for (int j = 0; j <= y; j++)
            for (int i = 0; i <= x; i++) begin
              s  += img[j][i];
              s2 += img[j][i] * img[j][i];
            end
          pix_q.push_back(8'(img[y][x]));
          pix_eot_q.push_back({(y == 3 && x == 3), (x == 3)});
          exp_ii_q.push_back(18'(s));
          exp_sii_q.push_back(26'(s2));
          exp_eot_q.push_back({(y == 3 && x == 3), (x == 3)});
        end
      end
    end
    fork
      begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send_a(pix_q[i], pix_eot_q[i]);
        end
      end
      begin
        for (int t = 0; t < 3000 && got < n; t++) begin
          @(posedge clk); #1;
          dout_ready_a = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (dout_valid_a !== 1'b1 || dout_ii_a !== h_ii || dout_sii_a !== h_sii || dout_eot_a !== h_eot) begin
              errors++; $display("FAIL bp_hold: got v=%0b ii=%0d sii=%0d eot=%b exp 1/%0d/%0d/%b",
                                 dout_valid_a, dout_ii_a, dout_sii_a, dout_eot_a, h_ii, h_sii, h_eot);
            end
          end
          if (dout_valid_a && dout_ready_a) begin
            logic [17:0] ei;
            logic [25:0] es;
            logic [1:0]  ee;
            ei = exp_ii_q.pop_front(); es = exp_sii_q.pop_front(); ee = exp_eot_q.pop_front();
            checks++;
            if (dout_ii_a !== ei || dout_sii_a !== es || dout_eot_a !== ee) begin
              errors++; $display("FAIL bp_word%0d: got ii=%0d sii=%0d eot=%b exp %0d/%0d/%b",
                                 got, dout_ii_a, dout_sii_a, dout_eot_a, ei, es, ee);
            end
            checks++;
            if (dout_ii_c !== ei || dout_sii_c !== 26'd0) begin
              errors++; $display("FAIL bp_nosii_word%0d: got ii=%0d sii=%0d exp %0d/0", got, dout_ii_c, dout_sii_c, ei);
            end
            got++;
            stalled = 1'b0;
          end else if (dout_valid_a) begin
            stalled = 1'b1; h_ii = dout_ii_a; h_sii = dout_sii_a; h_eot = dout_eot_a;
          end else begin
            stalled = 1'b0;
          end
        end
      end
    join
    checks++; if (got != n) begin errors++; $display("FAIL bp_count: got %0d words exp %0d", got, n); end
    dout_ready_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_short_row();
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL short_err_before: got %0b exp 0", err_a); end
    send_a(8'd1, 2'b00);
    send_a(8'd1, 2'b00);
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL short_err_mid: got %0b exp 0", err_a); end
    send_a(8'd1, 2'b01);
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL short_err_set: got %0b exp 1", err_a); end
    checks++; if (dout_eot_a !== 2'b01) begin errors++; $display("FAIL short_eot: got %b exp 01", dout_eot_a); end
    for (int x = 0; x < 4; x++) send_a(8'd1, (x == 3) ? 2'b11 : 2'b00);
    checks++; if (err_a !== 1'b1 || dout_eot_a !== 2'b11) begin
      errors++; $display("FAIL short_sticky: got err=%0b eot=%b exp 1/11", err_a, dout_eot_a);
    end
    send_a(8'd3, 2'b00);
    checks++; if (dout_ii_a !== 18'd3 || dout_sii_a !== 26'd9) begin
      errors++; $display("FAIL short_restart0: got ii=%0d sii=%0d exp 3/9", dout_ii_a, dout_sii_a);
    end
    send_a(8'd3, 2'b00);
    checks++; if (dout_ii_a !== 18'd6 || dout_sii_a !== 26'd18 || err_a !== 1'b1) begin
      errors++; $display("FAIL short_restart1: got ii=%0d sii=%0d err=%0b exp 6/18/1", dout_ii_a, dout_sii_a, err_a);
    end
  endtask

  task automatic test_reset_mid();
    pulse_rst();
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL mid_err_cleared: got %0b exp 0", err_a); end
    for (int i = 0; i < 7; i++) send_a(8'd1, (i == 3) ? 2'b01 : 2'b00);
    checks++; if (dout_ii_a !== 18'd6 || dout_sii_a !== 26'd6) begin
      errors++; $display("FAIL mid_pre: got ii=%0d sii=%0d exp 6/6", dout_ii_a, dout_sii_a);
    end
    dout_ready_a = 1'b0;
    pulse_rst();
    checks++;
    if (dout_valid_a !== 1'b0 || dout_ii_a !== 18'd0 || dout_sii_a !== 26'd0 || dout_eot_a !== 2'b00 || err_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got v=%0b ii=%0d sii=%0d eot=%b err=%0b exp all 0",
                         dout_valid_a, dout_ii_a, dout_sii_a, dout_eot_a, err_a);
    end
    dout_ready_a = 1'b1;
    send_a(8'd2, 2'b00);
    checks++; if (dout_ii_a !== 18'd2 || dout_sii_a !== 26'd4) begin
      errors++; $display("FAIL mid_fresh0: got ii=%0d sii=%0d exp 2/4", dout_ii_a, dout_sii_a);
    end
    send_a(8'd2, 2'b00);
    checks++; if (dout_ii_a !== 18'd4 || dout_sii_a !== 26'd8) begin
      errors++; $display("FAIL mid_fresh1: got ii=%0d sii=%0d exp 4/8", dout_ii_a, dout_sii_a);
    end
  endtask

  task automatic test_sii_disabled();
    pulse_rst();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        logic [1:0] e;
        int ex;
        e  = {(y == 3 && x == 3), (x == 3)};
        ex = (x + 1) * (y + 1);
        send_a(8'd1, e);
        checks++;
        if (dout_valid_c !== 1'b1 || dout_ii_c !== 18'(ex) || dout_sii_c !== 26'd0 || dout_eot_c !== e) begin
          errors++; $display("FAIL nosii(%0d,%0d): got v=%0b ii=%0d sii=%0d eot=%b exp 1/%0d/0/%b",
                             x, y, dout_valid_c, dout_ii_c, dout_sii_c, dout_eot_c, ex, e);
        end
      end
    end
    checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL nosii_err: got %0b exp 0", err_c); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_all_ones();
    test_full_scale();
    test_back_to_back();
    test_backpressure();
    test_short_row();
    test_reset_mid();
    test_sii_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ii_sii_stream_gen.md
# ii_sii_stream_gen

Streaming generator of the integral image (II) and squared integral image (SII) for the cascade classifier front end. It replaces the broadcast plus two independent `ii_gen` instances with one datapath. It consumes one pixel stream, keeps a shared column counter and row/frame bookkeeping, and emits II and SII on a single aligned output stream. Widths and image geometry are parametrised, SII can be disabled at build time, and row-length errors are detected.

## Interface

Parameters:
- `W_DATA`, default 8: pixel width.
- `IMG_WIDTH`, default 24: pixels per row, and depth of the column buffers.
- `W_II`, default 18: II accumulator and output width; arithmetic is modulo 2^W_II.
- `W_SII`, default 26: SII accumulator and output width; arithmetic is modulo 2^W_SII.
- `SII_EN`, default 1: 0 ties `dout_sii` to 0 and removes the squarer and SII buffer.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `din_valid`, in, 1: pixel valid.
- `din_ready`, out, 1: pixel accepted when `din_valid && din_ready`.
- `din_data`, in, W_DATA: unsigned pixel.
- `din_eot`, in, 2: bit0 marks the last pixel of a row; bit1 marks the last pixel of the frame (always sent with bit0).
- `dout_valid`, out, 1: II/SII word valid.
- `dout_ready`, in, 1: downstream ready.
- `dout_ii`, out, W_II: II(x,y).
- `dout_sii`, out, W_SII: SII(x,y).
- `dout_eot`, out, 2: `din_eot` of the pixel that produced this word.
- `err_row_len`, out, 1: sticky row-length error.

## Operation

- Definitions: II(x,y) = Σ p(i,j) over i≤x, j≤y. SII is the same sum over p².
- State:
  - column counter `x`, range 0..IMG_WIDTH-1;
  - row sums `rs_ii` and `rs_sii`;
  - column buffers `cb_ii[IMG_WIDTH]` and `cb_sii[IMG_WIDTH]`, asynchronous read at `x`;
  - flag `first_row`.
- On each accepted pixel p:
  - rs_ii' = (x==0 ? 0 : rs_ii) + p
  - ii = rs_ii' + (first_row ? 0 : cb_ii[x])
  - The same rule applies to SII using p², a full 2·W_DATA-bit product zero-extended.
  - Write cb_ii[x] ← ii and cb_sii[x] ← sii.
  - Register ii, sii and eot into the output stage.
- Column and row control, FSM states ROW0 (first_row=1) and ROWN (first_row=0):
  - Accepted pixel with eot[0]=1 and x==IMG_WIDTH-1: x←0. Then go to ROWN, or to ROW0 if eot[1]=1.
  - Accepted pixel with eot[0]=1 and x<IMG_WIDTH-1 (short row): set `err_row_len` and x←0. Move to ROW0 if eot[1]=1, else ROWN.
  - Accepted pixel with eot[0]=0 and x==IMG_WIDTH-1 (long row): set `err_row_len`, wrap x←0, go to ROWN.
  - Otherwise: x←x+1.
- Column buffers are never cleared. `first_row` masks stale contents, so frames run back-to-back with no gap.
- After an error, output values are unspecified until the next frame start. eot propagation and handshakes stay correct.
- `err_row_len` clears only on `rst`.
- Overflow wraps silently. The defaults cover a 24×24 frame of 8-bit pixels exactly.

## Timing

- One output register stage; latency is 1 cycle from input accept to `dout_valid`.
- `din_ready = !dout_valid || dout_ready`, combinational. The block sustains full throughput of 1 pixel/cycle.
- Output is held stable while `dout_valid && !dout_ready`. No state advances while an input is not accepted.
- A simultaneous output drain and input accept in the same cycle loads the new word; no bubble.
- The column buffer read for x and the write for x occur in the same accept cycle. The read sees the old value.
- Reset values:
  - `dout_valid`=0, `dout_ii`=0, `dout_sii`=0, `dout_eot`=0, `err_row_len`=0;
  - x=0, row sums 0, state ROW0.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame. Any output word pending at reset is dropped.

## Test plan

- **All-ones frame:** IMG_WIDTH=4, 4×4 frame of p=1 with correct eot → word at (x,y) has ii=sii=(x+1)(y+1). Last word is 16/16 with eot=2'b11.
- **Full-scale frame:** defaults, 24×24 of p=255 → final ii=146880 and sii=37454400, no wrap. A second back-to-back frame restarts at ii=255, sii=65025.
- **Random backpressure:** random pixels with `dout_ready` toggled randomly (~50%) → outputs match a reference model bit-exactly and in order. Data is held stable while stalled. Throughput is 1/cycle when `dout_ready`=1.
- **Short row:** IMG_WIDTH=4, row 0 with eot[0] at x=2 → `err_row_len`=1 from the following cycle and stays set. The next frame after eot[1] restarts at (0,0).
- **Reset mid-frame:** assert `rst` for 1 cycle after 7 pixels of a 4×4 frame → all outputs 0 next cycle. A fresh frame of p=2 yields first ii=2, sii=4.
- **SII_EN=0:** all-ones 4×4 frame → `dout_sii`=0 for every word, and `dout_ii` is the same as in the all-ones scenario.
